// File: rtl/scorehand_seq.sv
// Sequential hand scorer: accepts one card per handshake and keeps the running score mod MODULUS.
// Optional macro SCOREHAND_DRAW_RULE_EN adds the registered need_third output.
module scorehand_seq #(
   parameter int unsigned CARD_W      = 4,
   parameter int unsigned MAX_CARDS   = 3,
   parameter int unsigned MODULUS     = 10,
   parameter int unsigned NATURAL_MIN = 8,
   parameter int unsigned SCORE_W     = $clog2(MODULUS),
   parameter int unsigned CNT_W       = $clog2(MAX_CARDS + 1)
) (
   input  logic               slow_clock,
   input  logic               reset,
   input  logic               clear,
   input  logic               card_valid,
   input  logic [CARD_W-1:0]  card,
   output logic               card_ready,
   output logic [SCORE_W-1:0] score,
   output logic [CNT_W-1:0]   num_cards,
   output logic               hand_full,
   output logic               natural,
   output logic               score_valid
`ifdef SCOREHAND_DRAW_RULE_EN
   ,
   output logic               need_third
`endif
);

   typedef enum logic [1:0] {StEmpty, StPartial, StFull} state_t;

   state_t             state;
   logic [3:0]         card_val;
   logic [SCORE_W:0]   sum;
   logic [SCORE_W:0]   sum_red;
   logic [SCORE_W-1:0] acc_score;
   logic [CNT_W-1:0]   acc_cnt;
   logic               acc_full;
   logic               acc_nat;
   logic               accept;

   assign card_ready = !hand_full && !clear;
   assign accept     = card_valid && !clear && (state != StFull);

   // Card value, pre-reduced so one conditional subtraction always completes the modulo.
   always_comb begin
      card_val = 4'd0;
      if (32'(card) >= 1 && 32'(card) <= 9) card_val = 4'(32'(card));
      for (int i = 0; i < 8; i++) begin
         if (32'(card_val) >= MODULUS) card_val = card_val - 4'(MODULUS);
      end
   end

   always_comb begin
      sum = {1'b0, score} + (SCORE_W + 1)'(card_val);
      if (32'(sum) >= MODULUS) sum_red = sum - (SCORE_W + 1)'(MODULUS);
      else                     sum_red = sum;
      acc_score = sum_red[SCORE_W-1:0];
      acc_cnt   = num_cards + CNT_W'(1);
      acc_full  = (32'(acc_cnt) == MAX_CARDS);
      acc_nat   = (32'(acc_cnt) == 2) && (32'(acc_score) >= NATURAL_MIN);
   end

`ifdef SCOREHAND_DRAW_RULE_EN
   logic acc_draw;
   assign acc_draw = (32'(acc_cnt) == 2) && (32'(acc_score) <= 5) && !acc_nat;
`endif

   always_ff @(posedge slow_clock) begin
      if (reset || clear) begin
         state       <= StEmpty;
         score       <= '0;
         num_cards   <= '0;
         hand_full   <= 1'b0;
         natural     <= 1'b0;
         score_valid <= 1'b0;
`ifdef SCOREHAND_DRAW_RULE_EN
         need_third  <= 1'b0;
`endif
      end else if (accept) begin
         state       <= acc_full ? StFull : StPartial;
         score       <= acc_score;
         num_cards   <= acc_cnt;
         hand_full   <= acc_full;
         natural     <= acc_nat;
         score_valid <= 1'b1;
`ifdef SCOREHAND_DRAW_RULE_EN
         need_third  <= acc_draw;
`endif
      end else begin
         score_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_scorehand_seq.sv
// Directed-vector bench for scorehand_seq with default parameters.
// need_third checks are built only when SCOREHAND_DRAW_RULE_EN is defined.
module tb_scorehand_seq;

   logic       slow_clock = 1'b0;
   logic       reset;
   logic       clear;
   logic       card_valid;
   logic [3:0] card;
   logic       card_ready;
   logic [3:0] score;
   logic [1:0] num_cards;
   logic       hand_full;
   logic       natural;
   logic       score_valid;
`ifdef SCOREHAND_DRAW_RULE_EN
   logic       need_third;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   scorehand_seq dut (
      .slow_clock  (slow_clock),
      .reset       (reset),
      .clear       (clear),
      .card_valid  (card_valid),
      .card        (card),
      .card_ready  (card_ready),
      .score       (score),
      .num_cards   (num_cards),
      .hand_full   (hand_full),
      .natural     (natural),
      .score_valid (score_valid)
`ifdef SCOREHAND_DRAW_RULE_EN
      ,
      .need_third  (need_third)
`endif
   );

   always #5 slow_clock = ~slow_clock;

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge slow_clock);
      #1;
   endtask

   task automatic feed(input logic [3:0] c);
      card       = c;
      card_valid = 1'b1;
      tick();
      card_valid = 1'b0;
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
   endtask

   // Feed one card and check the resulting score/count/pulse.
   task automatic feed_chk(input string tag, input logic [3:0] c, input int exp_score,
                           input int exp_cnt);
      feed(c);
      check_eq({tag, " score"}, 32'(score), exp_score);
      check_eq({tag, " num_cards"}, 32'(num_cards), exp_cnt);
      check_eq({tag, " score_valid"}, 32'(score_valid), 1);
   endtask

   initial begin
      reset      = 1'b1;
      clear      = 1'b0;
      card_valid = 1'b0;
      card       = 4'd0;
      tick();
      tick();
      check_eq("rst score", 32'(score), 0);
      check_eq("rst num_cards", 32'(num_cards), 0);
      check_eq("rst hand_full", 32'(hand_full), 0);
      check_eq("rst natural", 32'(natural), 0);
      check_eq("rst score_valid", 32'(score_valid), 0);
      reset = 1'b0;
      #1;
      check_eq("rst card_ready", 32'(card_ready), 1);

      // 5, 8, 6 back to back
      feed_chk("h1c1", 4'd5, 5, 1);
      feed_chk("h1c2", 4'd8, 3, 2);
      check_eq("h1c2 natural", 32'(natural), 0);
      feed_chk("h1c3", 4'd6, 9, 3);
      check_eq("h1 hand_full", 32'(hand_full), 1);
      check_eq("h1 card_ready", 32'(card_ready), 0);
      tick();
      check_eq("h1 idle score_valid", 32'(score_valid), 0);
      check_eq("h1 idle score", 32'(score), 9);

      do_clear();
      check_eq("clr score", 32'(score), 0);
      check_eq("clr num_cards", 32'(num_cards), 0);
      check_eq("clr hand_full", 32'(hand_full), 0);
      check_eq("clr score_valid", 32'(score_valid), 0);

      // face/ten codes score 0
      feed_chk("h2c1", 4'd11, 0, 1);
      feed_chk("h2c2", 4'd4, 4, 2);
      feed_chk("h2c3", 4'd12, 4, 3);
      do_clear();
      feed_chk("h3c1", 4'd14, 0, 1);
      feed_chk("h3c2", 4'd15, 0, 2);
      check_eq("h3 natural", 32'(natural), 0);
      do_clear();

      // wrap through 17 and 16
      feed_chk("h4c1", 4'd9, 9, 1);
      check_eq("h4c1 natural", 32'(natural), 0);
      feed_chk("h4c2", 4'd8, 7, 2);
      check_eq("h4c2 natural", 32'(natural), 0);
      feed_chk("h4c3", 4'd9, 6, 3);
      check_eq("h4c3 natural", 32'(natural), 0);
      do_clear();

      // natural 9, then deasserts on third card; fourth ignored
      feed_chk("h5c1", 4'd4, 4, 1);
      feed_chk("h5c2", 4'd5, 9, 2);
      check_eq("h5c2 natural", 32'(natural), 1);
      check_eq("h5c2 hand_full", 32'(hand_full), 0);
      feed_chk("h5c3", 4'd0, 9, 3);
      check_eq("h5c3 natural", 32'(natural), 0);
      check_eq("h5c3 hand_full", 32'(hand_full), 1);
      card       = 4'd5;
      card_valid = 1'b1;
      #1;
      check_eq("h5 full card_ready", 32'(card_ready), 0);
      tick();
      card_valid = 1'b0;
      check_eq("h5 ignored score", 32'(score), 9);
      check_eq("h5 ignored num_cards", 32'(num_cards), 3);
      check_eq("h5 ignored score_valid", 32'(score_valid), 0);
      do_clear();

      // clear beats a simultaneous card
      feed_chk("h6c1", 4'd1, 1, 1);
      feed_chk("h6c2", 4'd2, 3, 2);
      clear      = 1'b1;
      card_valid = 1'b1;
      card       = 4'd7;
      #1;
      check_eq("h6 clear card_ready", 32'(card_ready), 0);
      tick();
      clear      = 1'b0;
      card_valid = 1'b0;
      check_eq("h6 clear score", 32'(score), 0);
      check_eq("h6 clear num_cards", 32'(num_cards), 0);
      check_eq("h6 clear score_valid", 32'(score_valid), 0);
      tick();
      check_eq("h6 after score", 32'(score), 0);
      check_eq("h6 after num_cards", 32'(num_cards), 0);

      // reset mid-hand beats card_valid
      feed_chk("h7c1", 4'd6, 6, 1);
      feed_chk("h7c2", 4'd7, 3, 2);
      reset      = 1'b1;
      card_valid = 1'b1;
      card       = 4'd2;
      tick();
      reset      = 1'b0;
      card_valid = 1'b0;
      check_eq("h7 rst score", 32'(score), 0);
      check_eq("h7 rst num_cards", 32'(num_cards), 0);
      check_eq("h7 rst hand_full", 32'(hand_full), 0);
      check_eq("h7 rst natural", 32'(natural), 0);
      check_eq("h7 rst score_valid", 32'(score_valid), 0);

`ifdef SCOREHAND_DRAW_RULE_EN
      check_eq("d rst need_third", 32'(need_third), 0);
      feed_chk("d1c1", 4'd2, 2, 1);
      check_eq("d1c1 need_third", 32'(need_third), 0);
      feed_chk("d1c2", 4'd3, 5, 2);
      check_eq("d1c2 need_third", 32'(need_third), 1);
      do_clear();
      check_eq("d clr need_third", 32'(need_third), 0);
      feed_chk("d2c1", 4'd3, 3, 1);
      feed_chk("d2c2", 4'd3, 6, 2);
      check_eq("d2c2 need_third", 32'(need_third), 0);
      do_clear();
      feed_chk("d3c1", 4'd2, 2, 1);
      feed_chk("d3c2", 4'd3, 5, 2);
      check_eq("d3c2 need_third", 32'(need_third), 1);
      feed_chk("d3c3", 4'd4, 9, 3);
      check_eq("d3c3 need_third", 32'(need_third), 0);
      do_clear();
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/scorehand_seq.md
Name: scorehand_seq

Overview:
Sequential, parametrised successor to the combinational hand scorer. Accepts one card per handshake and accumulates the hand score modulo MODULUS, up to MAX_CARDS cards per hand. Tracks card count, hand-full and natural status, so the game datapath/FSM can feed cards as they are dealt instead of presenting the whole hand at once. Instantiated once per hand (player, banker) in the datapath.

Parameters:
- CARD_W, 4: card code width. Codes 1..9 score face value; 0, 10..(2^CARD_W-1) score 0.
- MAX_CARDS, 3: maximum cards per hand, 1..15.
- MODULUS, 10: score modulus, 2..16.
- NATURAL_MIN, 8: a two-card score >= this is a natural. Must be < MODULUS.
- SCORE_W, $clog2(MODULUS): score width. Derived; not to be overridden.
- CNT_W, $clog2(MAX_CARDS+1): card-count width. Derived.

Ports:
- slow_clock  in  1  single clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- clear  in  1  start a new hand; synchronous, single-cycle pulse.
- card_valid  in  1  card presented on card.
- card  in  CARD_W  card code.
- card_ready  out  1  block can accept a card this cycle.
- score  out  SCORE_W  running hand score mod MODULUS (registered).
- num_cards  out  CNT_W  cards accepted in current hand.
- hand_full  out  1  num_cards == MAX_CARDS.
- natural  out  1  num_cards == 2 and score >= NATURAL_MIN.
- score_valid  out  1  pulses high for one cycle, the cycle after each accepted card.

Behaviour:
- Reset (reset=1 at an edge): score=0, num_cards=0, hand_full=0, natural=0, score_valid=0, state=EMPTY. Reset overrides clear and card_valid.
- States: EMPTY (num_cards=0), PARTIAL (0<num_cards<MAX_CARDS), FULL (num_cards==MAX_CARDS).
- card_ready = !hand_full && !clear (combinational from registered state and clear).
- Accept when card_valid && card_ready. On the next edge: score <= (score + value(card)) mod MODULUS; num_cards += 1; score_valid <= 1. Latency 1 cycle, throughput 1 card/cycle.
- Modulo arithmetic: compute the sum at SCORE_W+1 bits; subtract MODULUS once if sum >= MODULUS. value() <= 9 < 16, so one subtraction suffices whenever MODULUS > 9. For MODULUS <= 9, reduce value() mod MODULUS first. No divider.
- Transitions: EMPTY->PARTIAL on accept (->FULL if MAX_CARDS==1); PARTIAL->FULL when the accept makes num_cards==MAX_CARDS; FULL holds.
- card_valid while FULL: ignored, no state change, score_valid stays 0.
- clear: on the next edge score=0, num_cards=0, state=EMPTY, score_valid=0. clear has priority over a simultaneous card_valid; the card is not accepted (card_ready=0 that cycle).
- natural is registered and updates with num_cards/score. It deasserts when a third card is accepted.
- Outputs hold their values between accepts. A reset or clear asserted mid-hand abandons the hand with no partial effects.

Optional Feature:
- Macro: SCOREHAND_DRAW_RULE_EN.
- Defined: adds output port need_third (1 bit, registered). need_third = 1 iff num_cards==2 && score<=5 && !natural (player third-card rule). Reset/clear drive it to 0. It deasserts on the cycle after a third card is accepted.
- Undefined: port need_third is absent; no related logic.

Test Plan:
- Reset then feed 5, 8, 6 on consecutive cycles -> score_valid pulses each cycle; score 5, 3, 9; num_cards 1, 2, 3; hand_full=1 after the third; card_ready=0.
- Feed 11, 4, 12 -> score 0, 4, 4 (face/ten codes score 0). Feed 14, 15 after clear -> score 0, num_cards 2.
- Feed 9, 8, 9 -> score 9, 7, 6 (intermediate sum 17 > 4-bit-safe path); natural=0 throughout.
- Feed 4, 5 -> score 9, natural=1 after second card; feed 0 -> natural=0, hand_full=1. Fourth card_valid -> ignored, score stays 9, no score_valid.
- After 2 cards (score 3), assert clear together with card_valid=1, card=7 -> next cycle score=0, num_cards=0, card not accepted. Assert reset mid-hand -> all outputs 0.
- With SCOREHAND_DRAW_RULE_EN: cards 2, 3 -> need_third=1. Cards 3, 3 (score 6) -> 0. Cards 2, 3, 4 -> 1 then 0 after third card.
